// File: rtl/snitch_sim_ctrl_pkg.sv
// Shared types and defaults for the simulation controller.
// The optional watchdog is enabled with SNITCH_SIM_CTRL_WATCHDOG_EN.
package snitch_sim_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        HOST_WAIT  = 2'd2,
        DONE       = 2'd3
    } sim_state_e;

    localparam int unsigned DefaultTimeoutCode = 32'h7F;

    // Exit code drops the tohost "exit" flag bit, so it is one bit narrower than the data.
    typedef logic [30:0] exit_code_t;

    function automatic int unsigned exit_code_width(input int unsigned data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/snitch_sim_ctrl_wdt.sv
// Idle watchdog: down-counter that expires after Cycles enabled, uncleared cycles.
// Only instantiated when SNITCH_SIM_CTRL_WATCHDOG_EN is defined.
module snitch_sim_ctrl_wdt
    import snitch_sim_ctrl_pkg::*;
#(
    parameter int unsigned Cycles = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned    CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
    localparam logic [CntW-1:0] Load = CntW'(Cycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = Load;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // A clear in the expiry cycle counts as activity, so it suppresses the timeout.
    assign expire_o = en_i & ~clr_i & (cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= Load;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snitch_sim_ctrl.sv
// Simulation controller: cluster reset sequencing and tohost mailbox decode.
// Optional idle watchdog under SNITCH_SIM_CTRL_WATCHDOG_EN.
//
// state      | meaning
// RESET_HOLD | cluster held in reset, counting down RstCycles
// RUN        | cluster running, mailbox writes accepted
// HOST_WAIT  | syscall pending, waiting for host_ack_i
// DONE       | simulation finished, exit code frozen until reset
module snitch_sim_ctrl
    import snitch_sim_ctrl_pkg::*;
#(
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 32,
    parameter logic [AddrWidth-1:0] ToHostAddr     = '0,
    parameter int unsigned          RstCycles      = 16,
    parameter int unsigned          WatchdogCycles = 1_000_000,
    parameter int unsigned          TimeoutCode    = DefaultTimeoutCode
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 cluster_rst_no,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic                 host_req_o,
    output logic [DataWidth-1:0] host_data_o,
    input  logic                 host_ack_i,
    output logic                 done_o,
    output logic [DataWidth-2:0] exit_code_o
);

    localparam int unsigned ExitW = exit_code_width(DataWidth);
    localparam int unsigned RstW  = (RstCycles > 1) ? $clog2(RstCycles) : 1;

    sim_state_e           state_q, state_d;
    logic [RstW-1:0]      rst_cnt_q, rst_cnt_d;
    logic                 cluster_rst_q, cluster_rst_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 host_req_q, host_req_d;
    logic [DataWidth-1:0] host_data_q, host_data_d;
    logic                 done_q, done_d;
    logic [ExitW-1:0]     exit_code_q, exit_code_d;

    logic tohost_wr;
    logic wdt_expire;

    assign tohost_wr = wr_valid_i & wr_ready_q & (wr_addr_i == ToHostAddr);

`ifdef SNITCH_SIM_CTRL_WATCHDOG_EN
    logic wdt_clr;
    logic wdt_en;

    assign wdt_clr = tohost_wr | ((state_q == HOST_WAIT) & host_ack_i);
    assign wdt_en  = (state_q == RUN) | (state_q == HOST_WAIT);

    snitch_sim_ctrl_wdt #(
        .Cycles(WatchdogCycles)
    ) i_wdt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (wdt_clr),
        .en_i    (wdt_en),
        .expire_o(wdt_expire)
    );
`else
    logic unused_cfg;

    assign unused_cfg = ^{TimeoutCode, WatchdogCycles};
    assign wdt_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        host_data_d = host_data_q;
        exit_code_d = exit_code_q;
        case (state_q)
            RESET_HOLD: begin
                if (rst_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            RUN: begin
                // A real write outranks a watchdog expiry landing in the same cycle.
                if (tohost_wr && (wr_data_i != '0)) begin
                    if (wr_data_i[0]) begin
                        state_d     = DONE;
                        exit_code_d = wr_data_i[DataWidth-1:1];
                    end else begin
                        state_d     = HOST_WAIT;
                        host_data_d = wr_data_i;
                    end
                end else if (wdt_expire) begin
                    state_d     = DONE;
                    exit_code_d = ExitW'(TimeoutCode);
                end
            end
            HOST_WAIT: begin
                if (host_ack_i) begin
                    state_d = RUN;
                end else if (wdt_expire) begin
                    state_d     = DONE;
                    exit_code_d = ExitW'(TimeoutCode);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RESET_HOLD;
            end
        endcase

        cluster_rst_d = (state_d != RESET_HOLD);
        wr_ready_d    = (state_d == RUN);
        host_req_d    = (state_d == HOST_WAIT);
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= RESET_HOLD;
            rst_cnt_q     <= RstW'(RstCycles - 1);
            cluster_rst_q <= 1'b0;
            wr_ready_q    <= 1'b0;
            host_req_q    <= 1'b0;
            host_data_q   <= '0;
            done_q        <= 1'b0;
            exit_code_q   <= '0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cluster_rst_q <= cluster_rst_d;
            wr_ready_q    <= wr_ready_d;
            host_req_q    <= host_req_d;
            host_data_q   <= host_data_d;
            done_q        <= done_d;
            exit_code_q   <= exit_code_d;
        end
    end

    assign cluster_rst_no = cluster_rst_q;
    assign wr_ready_o     = wr_ready_q;
    assign host_req_o     = host_req_q;
    assign host_data_o    = host_data_q;
    assign done_o         = done_q;
    assign exit_code_o    = exit_code_q;

endmodule

// File: tb/tb_snitch_sim_ctrl.sv
// Self-checking bench for snitch_sim_ctrl: vector table, corner sequences and
// randomized traffic against a behavioural model (honours SNITCH_SIM_CTRL_WATCHDOG_EN).
module tb_snitch_sim_ctrl;

    localparam logic [31:0] TOHOST  = 32'h0000_1000;
    localparam int          RST_CYC = 16;
    localparam int          WDOG    = 100;
    localparam logic [30:0] TIMEOUT = 31'h7F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cluster_rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        host_req;
    logic [31:0] host_data;
    logic        host_ack;
    logic        done;
    logic [30:0] exit_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snitch_sim_ctrl #(
        .AddrWidth     (32),
        .DataWidth     (32),
        .ToHostAddr    (TOHOST),
        .RstCycles     (RST_CYC),
        .WatchdogCycles(WDOG),
        .TimeoutCode   (32'h7F)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cluster_rst_no(cluster_rst_n),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .host_req_o    (host_req),
        .host_data_o   (host_data),
        .host_ack_i    (host_ack),
        .done_o        (done),
        .exit_code_o   (exit_code)
    );

    // Behavioural model: edges since reset release, a syscall flag, a finished flag
    // and an idle-cycle count compared against the watchdog limit.
    int          since_rst;
    int          idle;
    bit          m_rel, m_req, m_done;
    logic [31:0] m_hdata;
    logic [30:0] m_code;

    function automatic void model_step();
        bit tohost;
        bit timeout;
        if (!rst_n) begin
            since_rst = 0; idle = 0;
            m_rel = 0; m_req = 0; m_done = 0; m_hdata = '0; m_code = '0;
            return;
        end
        if (!m_rel) begin
            since_rst++;
            if (since_rst >= RST_CYC) m_rel = 1;
            return;
        end
        if (m_done) return;
        tohost  = !m_req && wr_valid && (wr_addr == TOHOST);
        timeout = 0;
`ifdef SNITCH_SIM_CTRL_WATCHDOG_EN
        if (tohost || (m_req && host_ack)) begin
            idle = 0;
        end else begin
            idle++;
            timeout = (idle >= WDOG);
        end
`endif
        if (m_req) begin
            if (host_ack) m_req = 0;
            else if (timeout) begin m_done = 1; m_code = TIMEOUT; end
        end else if (tohost && (wr_data != 0)) begin
            if (wr_data[0]) begin m_done = 1; m_code = wr_data[31:1]; end
            else begin m_req = 1; m_hdata = wr_data; end
        end else if (timeout) begin
            m_done = 1; m_code = TIMEOUT;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are set at a negedge; the edge is applied and outputs checked at the next negedge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("m_cluster_rst", {31'b0, cluster_rst_n}, {31'b0, m_rel});
        check("m_wr_ready", {31'b0, wr_ready}, {31'b0, (m_rel && !m_req && !m_done)});
        check("m_host_req", {31'b0, host_req}, {31'b0, m_req});
        check("m_host_data", host_data, m_hdata);
        check("m_done", {31'b0, done}, {31'b0, m_done});
        check("m_exit_code", {1'b0, exit_code}, {1'b0, m_code});
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_addr = '0; wr_data = '0; host_ack = 0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        wr_valid = 1; wr_addr = a; wr_data = d; host_ack = 0;
        tick();
        idle_inputs();
    endtask

    task automatic reset_release();
        idle_inputs();
        rst_n = 0;
        tick();
        check("rst_cluster", {31'b0, cluster_rst_n}, 32'd0);
        check("rst_ready", {31'b0, wr_ready}, 32'd0);
        check("rst_req", {31'b0, host_req}, 32'd0);
        check("rst_hdata", host_data, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_code", {1'b0, exit_code}, 32'd0);
        rst_n = 1;
        for (int i = 1; i <= RST_CYC; i++) begin
            tick();
            if (i < RST_CYC) begin
                check("hold_cluster", {31'b0, cluster_rst_n}, 32'd0);
            end else begin
                check("release_cluster", {31'b0, cluster_rst_n}, 32'd1);
                check("release_ready", {31'b0, wr_ready}, 32'd1);
            end
        end
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ack;
        logic        exp_rdy;
        logic        exp_req;
        logic [31:0] exp_hdata;
        logic        exp_done;
        logic [30:0] exp_code;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_2000, 32'h1,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 31'd0};
        vecs[1] = '{1'b1, TOHOST,        32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 31'd0};
        vecs[2] = '{1'b1, TOHOST,        32'h8000_1000, 1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, 31'd0};
        vecs[3] = '{1'b1, TOHOST,        32'h3,         1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, 31'd0};
        vecs[4] = '{1'b1, TOHOST,        32'h3,         1'b1, 1'b1, 1'b0, 32'h8000_1000, 1'b0, 31'd0};
        vecs[5] = '{1'b1, TOHOST,        32'h15,        1'b0, 1'b0, 1'b0, 32'h8000_1000, 1'b1, 31'd10};
        vecs[6] = '{1'b1, TOHOST,        32'h3,         1'b1, 1'b0, 1'b0, 32'h8000_1000, 1'b1, 31'd10};
        vecs[7] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h8000_1000, 1'b1, 31'd10};

        rst_n = 0;
        idle_inputs();
        model_step();
        @(negedge clk);

        // Release timing, then the vector table from a fresh RUN state.
        reset_release();
        foreach (vecs[i]) begin
            wr_valid = vecs[i].valid; wr_addr = vecs[i].addr;
            wr_data = vecs[i].data; host_ack = vecs[i].ack;
            tick();
            check($sformatf("vec%0d_ready", i), {31'b0, wr_ready}, {31'b0, vecs[i].exp_rdy});
            check($sformatf("vec%0d_req", i), {31'b0, host_req}, {31'b0, vecs[i].exp_req});
            check($sformatf("vec%0d_hdata", i), host_data, vecs[i].exp_hdata);
            check($sformatf("vec%0d_done", i), {31'b0, done}, {31'b0, vecs[i].exp_done});
            check($sformatf("vec%0d_code", i), {1'b0, exit_code}, {1'b0, vecs[i].exp_code});
        end
        idle_inputs();

        // Exit code zero.
        reset_release();
        write(TOHOST, 32'h1);
        check("exit1_done", {31'b0, done}, 32'd1);
        check("exit1_code", {1'b0, exit_code}, 32'd0);

        // Reset pulse in the middle of a syscall; the release sequence must repeat.
        write(TOHOST, 32'h8000_1000);
        reset_release();
        write(TOHOST, 32'h8000_1000);
        tick();
        check("sys_req", {31'b0, host_req}, 32'd1);
        check("sys_ready", {31'b0, wr_ready}, 32'd0);
        reset_release();

        // Idle watchdog expiry.
        for (int i = 0; i < WDOG - 1; i++) tick();
        check("wdog_before", {31'b0, done}, 32'd0);
        tick();
`ifdef SNITCH_SIM_CTRL_WATCHDOG_EN
        check("wdog_done", {31'b0, done}, 32'd1);
        check("wdog_code", {1'b0, exit_code}, {1'b0, TIMEOUT});
`else
        for (int i = 0; i < 9 * WDOG; i++) tick();
        check("nowdog_done", {31'b0, done}, 32'd0);
`endif

        // Exit write landing on the expiry cycle wins.
        reset_release();
        for (int i = 0; i < WDOG - 1; i++) tick();
        write(TOHOST, 32'h15);
        check("collide_done", {31'b0, done}, 32'd1);
        check("collide_code", {1'b0, exit_code}, 32'd10);

        // Randomized traffic; every third episode is nearly idle to reach the watchdog.
        for (int ep = 0; ep < 10; ep++) begin
            int vprob;
            reset_release();
            vprob = (ep % 3 == 0) ? 2 : 60;
            for (int c = 0; c < 400; c++) begin
                int r;
                rst_n    = ($urandom_range(0, 499) != 0);
                wr_valid = ($urandom_range(0, 99) < vprob);
                wr_addr  = ($urandom_range(0, 3) == 0) ? $urandom : TOHOST;
                r = $urandom_range(0, 39);
                if (r < 4)       wr_data = '0;
                else if (r == 4) wr_data = $urandom | 32'h1;
                else             wr_data = $urandom & 32'hFFFF_FFFE;
                host_ack = ($urandom_range(0, 3) == 0);
                tick();
            end
            rst_n = 1;
            idle_inputs();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
